// File: rtl/bit_expand_ctrl.sv
// bit_expand_ctrl: sequences a single bit-expansion job on an external expander.
// It captures the index mask and the compressed vector, loads the expander, runs
// it until it reports done, and then captures the expanded result.
// Optional feature: define BIT_EXPAND_CTRL_TIMEOUT_EN to add a RUN-state watchdog
// that raises err. Without it, err is tied low and RUN waits indefinitely.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; index/short_b captured when a start is accepted
// LOAD_IDX | exp_index_valid strobe (also clears any stale expander done)
// LOAD_HI  | first half-word strobe, short[255:128]
// LOAD_LO  | second half-word strobe, short[127:0]; honours a deferred abort
// RUN      | exp_en held high until exp_done (or watchdog expiry)
// FINISH   | result_valid pulse; result captured on entry
module bit_expand_ctrl (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  logic [449:0] index_in,
  input  logic [255:0] short_b_in,
  output logic         busy,
  output logic         result_valid,
  output logic [449:0] result,
  output logic         err,
  output logic         exp_index_valid,
  output logic [449:0] exp_index,
  output logic         exp_read_short_b,
  output logic [127:0] exp_short_b,
  output logic         exp_en,
  input  logic         exp_done,
  input  logic [449:0] exp_expanded_b
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_IDX = 3'd1,
    LOAD_HI  = 3'd2,
    LOAD_LO  = 3'd3,
    RUN      = 3'd4,
    FINISH   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // An abort arriving in LOAD_HI is parked here so the LO strobe still goes out
  // and the expander's half-select toggle ends on its reset parity.
  logic abort_pend_q, abort_pend_d;

  logic [449:0] idx_q;
  logic [255:0] short_q;

  logic         busy_q;
  logic         result_valid_q;
  logic         err_q;
  logic         exp_index_valid_q;
  logic         exp_read_short_b_q;
  logic         exp_en_q;
  logic [449:0] result_q;
  logic [127:0] exp_short_b_q;

  logic capture;
  logic wd_expire;
  logic timeout_fire;

  // start is only honoured in IDLE, and a simultaneous abort wins over it
  assign capture = (state_q == IDLE) && start && !abort;

`ifdef BIT_EXPAND_CTRL_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'd599;

  logic [9:0] wd_q;

  // Watchdog: zeroed on the edge that enters RUN, counts every RUN cycle after that
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= 10'd0;
    end else if ((state_d == RUN) && (state_q != RUN)) begin
      wd_q <= 10'd0;
    end else if (state_q == RUN) begin
      wd_q <= wd_q + 10'd1;
    end
  end

  // Expiry is flagged on the cycle whose edge brings the count to 600
  assign wd_expire = (wd_q == WD_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  // A timeout only counts if nothing else already ends the RUN on this edge
  assign timeout_fire = (state_q == RUN) && !abort && !exp_done && wd_expire;

  // Next-state logic: abort priority, deferred abort across the half-word pair
  always_comb begin
    state_d      = state_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (capture) state_d = LOAD_IDX;
      end
      LOAD_IDX: begin
        state_d = abort ? IDLE : LOAD_HI;
      end
      LOAD_HI: begin
        state_d = LOAD_LO;
        if (abort) abort_pend_d = 1'b1;
      end
      LOAD_LO: begin
        state_d      = (abort || abort_pend_q) ? IDLE : RUN;
        abort_pend_d = 1'b0;
      end
      RUN: begin
        if (abort)             state_d = IDLE;
        else if (exp_done)     state_d = FINISH;
        else if (timeout_fire) state_d = IDLE;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        abort_pend_d = 1'b0;
      end
    endcase
  end

  // State and deferred-abort registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Captured job inputs; the index register feeds exp_index directly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q   <= '0;
      short_q <= '0;
    end else if (capture) begin
      idx_q   <= index_in;
      short_q <= short_b_in;
    end
  end

  // Registered control outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q             <= 1'b0;
      result_valid_q     <= 1'b0;
      err_q              <= 1'b0;
      exp_index_valid_q  <= 1'b0;
      exp_read_short_b_q <= 1'b0;
      exp_en_q           <= 1'b0;
    end else begin
      busy_q             <= (state_d != IDLE);
      result_valid_q     <= (state_d == FINISH);
      err_q              <= timeout_fire;
      exp_index_valid_q  <= (state_d == LOAD_IDX);
      exp_read_short_b_q <= (state_d == LOAD_HI) || (state_d == LOAD_LO);
      exp_en_q           <= (state_d == RUN);
    end
  end

  // Half-word data register: upper half first, then lower half; held otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_short_b_q <= '0;
    end else if (state_d == LOAD_HI) begin
      exp_short_b_q <= short_q[255:128];
    end else if (state_d == LOAD_LO) begin
      exp_short_b_q <= short_q[127:0];
    end
  end

  // Result changes only on the RUN->FINISH edge and survives IDLE and abort
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
    end else if ((state_q == RUN) && (state_d == FINISH)) begin
      result_q <= exp_expanded_b;
    end
  end

  assign busy             = busy_q;
  assign result_valid     = result_valid_q;
  assign result           = result_q;
  assign err              = err_q;
  assign exp_index_valid  = exp_index_valid_q;
  assign exp_index        = idx_q;
  assign exp_read_short_b = exp_read_short_b_q;
  assign exp_short_b      = exp_short_b_q;
  assign exp_en           = exp_en_q;

endmodule

// File: tb/tb_bit_expand_ctrl.sv
// Testbench for bit_expand_ctrl, with a behavioural expander attached.
// Set BIT_EXPAND_CTRL_TIMEOUT_EN to exercise the watchdog path.
`timescale 1ns/1ps
module tb_bit_expand_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, abort;
  logic [449:0] index_in;
  logic [255:0] short_b_in;
  logic         busy, result_valid, err;
  logic [449:0] result;
  logic         exp_index_valid, exp_read_short_b, exp_en;
  logic [449:0] exp_index;
  logic [127:0] exp_short_b;
  logic         exp_done;
  logic [449:0] exp_expanded_b;

  int ntests = 0;
  int nfail  = 0;
  int n      = 0;
  bit hold_done = 1'b0;
  logic [449:0] last_res;

  always #5 clk = ~clk;

  bit_expand_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .index_in(index_in), .short_b_in(short_b_in),
    .busy(busy), .result_valid(result_valid), .result(result), .err(err),
    .exp_index_valid(exp_index_valid), .exp_index(exp_index),
    .exp_read_short_b(exp_read_short_b), .exp_short_b(exp_short_b),
    .exp_en(exp_en), .exp_done(exp_done), .exp_expanded_b(exp_expanded_b)
  );

  // Expander model: the index strobe restarts it, and half-word strobes alternate hi/lo
  // through a parity toggle. It then handles one index bit per exp_en cycle for 450
  // cycles, and done rises two edges after the last bit.
  logic [449:0] m_idx, m_acc;
  logic [255:0] m_short;
  logic         m_half, m_done_pre;
  int           m_cnt, m_used;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_idx <= '0; m_acc <= '0; m_short <= '0; m_half <= 1'b0;
      m_done_pre <= 1'b0; exp_done <= 1'b0; m_cnt <= 0; m_used <= 0;
    end else begin
      if (exp_read_short_b) begin
        if (!m_half) m_short[255:128] <= exp_short_b;
        else         m_short[127:0]   <= exp_short_b;
        m_half <= ~m_half;
      end
      if (exp_index_valid) begin
        m_idx <= exp_index; m_acc <= '0; m_cnt <= 0; m_used <= 0;
        m_done_pre <= 1'b0; exp_done <= 1'b0;
      end else begin
        if (exp_en && m_cnt < 450) begin
          if (m_idx[449-m_cnt]) begin
            if (m_used < 256) m_acc[449-m_cnt] <= m_short[255-m_used];
            m_used <= m_used + 1;
          end
          m_cnt <= m_cnt + 1;
          if (m_cnt == 449) m_done_pre <= 1'b1;
        end
        exp_done <= m_done_pre && !hold_done;
      end
    end
  end
  assign exp_expanded_b = m_acc;

  // Reference: a set index bit at position p takes short bit (255 - rank), where rank is
  // the number of set index bits above p. Once rank reaches 256, the output bit is 0.
  function automatic logic [449:0] ref_expand(input logic [449:0] idx, input logic [255:0] sh);
    logic [449:0] r;
    int rank;
    r = '0;
    rank = 0;
    for (int p = 449; p >= 0; p--) begin
      if (idx[p]) begin
        if (rank < 256) r[p] = sh[255-rank];
        rank++;
      end
    end
    return r;
  endfunction

  function automatic logic [449:0] rand450();
    logic [479:0] t;
    for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom();
    return t[449:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    return t;
  endfunction

  function automatic logic [449:0] flags();
    return 450'({busy, exp_index_valid, exp_read_short_b, exp_en, result_valid, err});
  endfunction

  task automatic chk(input string tag, input logic [449:0] obs, input logic [449:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge just after E0 (n=0)
  task automatic launch(input logic [449:0] idx, input logic [255:0] sh);
    start = 1'b1; index_in = idx; short_b_in = sh;
    @(negedge clk);
    n = 0;
    start = 1'b0; index_in = rand450(); short_b_in = rand256();
  endtask

  // flags order: busy, exp_index_valid, exp_read_short_b, exp_en, result_valid, err
  task automatic check_load(input string tag, input logic [449:0] idx, input logic [255:0] sh);
    chk({tag, "_lidx"}, flags(), 450'(6'b110000));
    chk({tag, "_index"}, exp_index, idx);
    step();
    chk({tag, "_lhi"}, flags(), 450'(6'b101000));
    chk({tag, "_hi"}, 450'(exp_short_b), 450'(sh[255:128]));
    step();
    chk({tag, "_llo"}, flags(), 450'(6'b101000));
    chk({tag, "_lo"}, 450'(exp_short_b), 450'(sh[127:0]));
    step();
    chk({tag, "_run"}, flags(), 450'(6'b100100));
  endtask

  task automatic wait_result(input string tag, input logic [449:0] exp_res);
    int lat;
    bit early, err_seen;
    lat = -1; early = 1'b0; err_seen = 1'b0;
    while (n <= 1000) begin
      if (result_valid) begin
        lat = n;
        break;
      end
      if (result !== last_res) early = 1'b1;
      if (err) err_seen = 1'b1;
      step();
    end
    chk({tag, "_latency"}, 450'(lat), 450'(455));
    chk({tag, "_held"}, 450'({early, err_seen}), 450'(0));
    chk({tag, "_result"}, result, exp_res);
    step();
    chk({tag, "_post"}, flags(), 450'(0));
    chk({tag, "_persist"}, result, exp_res);
    last_res = exp_res;
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (result_valid || busy) seen = 1'b1;
      step();
    end
    chk({tag, "_quiet"}, 450'(seen), 450'(0));
    chk({tag, "_keep"}, result, last_res);
  endtask

  initial begin
    logic [449:0] idx, idx2;
    logic [255:0] sh, sh2;

    resetn = 1'b0; start = 1'b0; abort = 1'b0; index_in = '0; short_b_in = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", flags(), 450'(0));
    chk("rst_result", result, 450'(0));
    chk("rst_index", exp_index, 450'(0));
    chk("rst_short", 450'(exp_short_b), 450'(0));
    resetn = 1'b1;
    @(negedge clk);

    // All-ones index: the top 256 result bits carry short_b verbatim, the rest are zero
    idx = '1;
    sh  = {4{64'h0123456789ABCDEF}};
    launch(idx, sh);
    check_load("ones", idx, sh);
    wait_result("ones", {sh, 194'b0});

    // One-hot index at bit 449 with short_b[255]=1
    idx = '0; idx[449] = 1'b1;
    sh  = rand256(); sh[255] = 1'b1;
    launch(idx, sh);
    check_load("onehot", idx, sh);
    wait_result("onehot", {1'b1, 449'b0});

    // Two operations back to back (stale exp_done left over from the previous job)
    for (int k = 0; k < 2; k++) begin
      idx = rand450(); sh = rand256();
      launch(idx, sh);
      check_load("b2b", idx, sh);
      wait_result("b2b", ref_expand(idx, sh));
    end

    // Random masks, both sparse and dense
    for (int k = 0; k < 3; k++) begin
      idx = (k == 0) ? (rand450() & rand450() & rand450()) :
            (k == 1) ? (rand450() | rand450()) : rand450();
      sh = rand256();
      launch(idx, sh);
      check_load("rnd", idx, sh);
      wait_result("rnd", ref_expand(idx, sh));
    end

    // Abort seen in LOAD_HI: the LO strobe still goes out, then IDLE
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abhi_lo", flags(), 450'(6'b101000));
    chk("abhi_lodata", 450'(exp_short_b), 450'(sh[127:0]));
    step();
    chk("abhi_idle", flags(), 450'(0));
    quiet_check("abhi", 500);
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    check_load("abhi_next", idx, sh);
    wait_result("abhi_next", ref_expand(idx, sh));

    // Abort seen in LOAD_IDX
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abidx_idle", flags(), 450'(0));
    quiet_check("abidx", 20);

    // Abort during RUN
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    check_load("abrun", idx, sh);
    while (n < 100) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abrun_idle", flags(), 450'(0));
    quiet_check("abrun", 500);

    // start pulsed while busy is ignored; the original job completes unchanged
    idx = rand450(); sh = rand256();
    idx2 = rand450(); sh2 = rand256();
    launch(idx, sh);
    check_load("sbusy", idx, sh);
    while (n < 50) step();
    start = 1'b1; index_in = idx2; short_b_in = sh2;
    step();
    start = 1'b0;
    chk("sbusy_flags", flags(), 450'(6'b100100));
    chk("sbusy_index", exp_index, idx);
    wait_result("sbusy", ref_expand(idx, sh));

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1; index_in = rand450(); short_b_in = rand256();
    step();
    start = 1'b0; abort = 1'b0;
    chk("stab_flags", flags(), 450'(0));
    chk("stab_index", exp_index, idx);
    quiet_check("stab", 10);

    // Reset in the middle of RUN clears everything, and the next job is correct
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    while (n < 200) step();
    resetn = 1'b0;
    #1;
    chk("mrst_flags", flags(), 450'(0));
    chk("mrst_result", result, 450'(0));
    @(negedge clk);
    resetn = 1'b1;
    last_res = '0;
    @(negedge clk);
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    check_load("mrst_next", idx, sh);
    wait_result("mrst_next", ref_expand(idx, sh));

    // Expander never reports done
    hold_done = 1'b1;
    idx = rand450(); sh = rand256();
    launch(idx, sh);
    check_load("wd", idx, sh);
`ifdef BIT_EXPAND_CTRL_TIMEOUT_EN
    begin
      bit rv_seen;
      rv_seen = 1'b0;
      while (!err && n < 1000) begin
        if (result_valid) rv_seen = 1'b1;
        step();
      end
      chk("wd_err_at", 450'(n), 450'(603));
      chk("wd_no_rv", 450'({rv_seen, result_valid}), 450'(0));
      step();
      chk("wd_idle", flags(), 450'(0));
      chk("wd_keep", result, last_res);
    end
`else
    begin
      bit err_seen;
      err_seen = 1'b0;
      while (n < 700) begin
        if (err) err_seen = 1'b1;
        step();
      end
      chk("nowd_wait", flags(), 450'(6'b100100));
      chk("nowd_err", 450'(err_seen), 450'(0));
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("nowd_abort", flags(), 450'(0));
      chk("nowd_keep", result, last_res);
    end
`endif
    hold_done = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bit_expand_ctrl.md
BIT_EXPAND_CTRL -- requirements
Module: bit_expand_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  request one expansion; sampled only in IDLE.
REQ-004 SHALL have port abort  input  1  cancel the current operation.
REQ-005 SHALL have port index_in  input  450  selection mask; bit 449 is consumed first.
REQ-006 SHALL have port short_b_in  input  256  compressed B_I vector.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port result_valid  output  1  one-cycle pulse when result is valid.
REQ-009 SHALL have port result  output  450  captured expanded B vector.
REQ-010 SHALL have port err  output  1  one-cycle pulse on watchdog timeout.
REQ-011 SHALL have port exp_index_valid  output  1  index load strobe to the expander.
REQ-012 SHALL have port exp_index  output  450  index to the expander.
REQ-013 SHALL have port exp_read_short_b  output  1  half-word load strobe to the expander.
REQ-014 SHALL have port exp_short_b  output  128  half-word to the expander.
REQ-015 SHALL have port exp_en  output  1  expansion enable to the expander.
REQ-016 SHALL have port exp_done  input  1  expander completion, level, cleared by exp_index_valid.
REQ-017 SHALL have port exp_expanded_b  input  450  expander output vector.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD_IDX, LOAD_HI, LOAD_LO, RUN and FINISH, with all outputs registered.
REQ-019 SHALL, in IDLE with start=1 and abort=0, capture index_in and short_b_in into internal registers and go to LOAD_IDX.
REQ-020 SHALL ignore start when not in IDLE, and SHALL ignore start when abort=1 in the same cycle.
REQ-021 SHALL drive exp_index_valid=1 with the captured index in LOAD_IDX for exactly 1 cycle, then go to LOAD_HI.
REQ-022 SHALL drive exp_read_short_b=1 with exp_short_b=short[255:128] in LOAD_HI, and with exp_short_b=short[127:0] in LOAD_LO; each state lasts 1 cycle.
REQ-023 SHALL always issue the two half-word strobes as an adjacent pair, so that the expander's internal half-select toggle returns to its reset parity.
REQ-024 SHALL hold exp_en=1 in RUN, keep exp_read_short_b=0 and exp_index_valid=0 there, and go to FINISH on the first cycle with exp_done=1.
REQ-025 SHALL, on the RUN->FINISH edge, latch exp_expanded_b into result and set result_valid=1 for exactly 1 cycle (FINISH), then return to IDLE.
REQ-026 SHALL deliver nominal latency from the start-sampling edge E0: result_valid high after edge E0+455 (1 cycle LOAD_IDX, 2 cycles load, 450 cycles expand, 2 cycles expander done registration).
REQ-027 SHALL hold result unchanged except at the capture edge; result persists across IDLE and abort.
REQ-028 SHALL, on abort in LOAD_IDX, RUN or FINISH, return to IDLE at the next edge with exp_en=0 and without pulsing result_valid (an abort seen in FINISH does not suppress the pulse already in progress).
REQ-029 SHALL, on abort in LOAD_HI, defer the abort until after LOAD_LO completes, to preserve strobe pairing.
REQ-030 SHALL not sample exp_done in any state other than RUN; a stale exp_done from a prior operation is cleared by LOAD_IDX before RUN.

Reset
REQ-031 SHALL, on resetn=0, enter IDLE immediately.
REQ-032 SHALL, on resetn=0, clear busy, result_valid, err, exp_index_valid, exp_read_short_b and exp_en to 0.
REQ-033 SHALL, on resetn=0, clear result, exp_index, exp_short_b, the captured input registers and the watchdog counter to 0.
REQ-034 SHALL treat reset mid-operation as abort with no output pulse, and SHALL require the expander to be reset by the same resetn.

Configuration
REQ-035 SHALL, with BIT_EXPAND_CTRL_TIMEOUT_EN defined, include a 10-bit watchdog cleared on RUN entry and incremented each RUN cycle.
REQ-036 SHALL, with BIT_EXPAND_CTRL_TIMEOUT_EN defined, pulse err for 1 cycle and return to IDLE with no result_valid when the watchdog reaches 600 without exp_done.
REQ-037 SHALL, without BIT_EXPAND_CTRL_TIMEOUT_EN, omit the watchdog, tie err to 0 and wait in RUN indefinitely.

Verification
REQ-038 SHALL cover: index=all-ones, short_b=256'h0123..EF (repeating) -> result_valid at E0+455; result[449:194]=short_b, result[193:0]=0.
REQ-039 SHALL cover: index=one-hot bit 449, short_b[255]=1 -> result = 450'b1 followed by 449 zeros; the exp_* strobe sequence is 1/1/1 cycles in the required order.
REQ-040 SHALL cover: two back-to-back operations with different data -> second result correct; exp_short_b halves arrive hi-then-lo both times (parity preserved).
REQ-041 SHALL cover: abort asserted in LOAD_HI -> LOAD_LO still issued, then IDLE; no result_valid; next start produces a correct result.
REQ-042 SHALL cover: start pulsed while busy, and start+abort together in IDLE -> both ignored, busy and exp_* unchanged.
REQ-043 SHALL cover, with BIT_EXPAND_CTRL_TIMEOUT_EN defined: exp_done forced 0 -> err pulse 600 cycles after RUN entry, then IDLE, result unchanged.
